// File: rtl/typer_pkg.sv
// rtl/typer_pkg.sv - shared definitions for the typer multicycle R-type core
//
// Purpose: funct codes, halt word, FSM state encoding and instruction field
// positions used by typer_multicycle and typer_alu.
// Ports: none (package).

package typer_pkg;

  // Supported R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;

  // All-ones word stops the program
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    case (funct)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR,
      FUNCT_NOR, FUNCT_SLT, FUNCT_SLL, FUNCT_SRL: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/typer_alu.sv
// rtl/typer_alu.sv - combinational R-type ALU
//
// Purpose: computes the result of one supported R-type funct.
// Ports:
//   a, b    operands (DATA_W)
//   shamt   5-bit shift amount from the instruction
//   funct   6-bit funct code
//   result  DATA_W result; unsupported funct yields 0

module typer_alu
  import typer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result
);

  // Shift distance wraps at the data width so narrow cores never shift
  // everything out on a large shamt.
  logic [6:0] sh;

  always_comb begin
    sh = 7'(32'(shamt) % DATA_W);
  end

  always_comb begin
    result = '0;
    case (funct)
      FUNCT_ADD: result = a + b;
      FUNCT_SUB: result = a - b;
      FUNCT_AND: result = a & b;
      FUNCT_OR:  result = a | b;
      FUNCT_NOR: result = ~(a | b);
      FUNCT_SLT: result[0] = ($signed(a) < $signed(b));
      FUNCT_SLL: result = b << sh;
      FUNCT_SRL: result = b >> sh;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/typer_multicycle.sv
// rtl/typer_multicycle.sv - multicycle MIPS R-type execution core
//
// Purpose: fetch / decode / execute / write-back of R-type words held in an
// internal instruction memory, with a 32-entry register file, start/halt
// handshake, retire counter and sticky illegal-opcode flag.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   imem_we/imem_waddr/wdata    host instruction-memory write (idle only)
//   dbg_we/dbg_addr/dbg_wdata   host register write (idle only, r0 discarded)
//   dbg_rdata                   combinational read of reg[dbg_addr]
//   start                       run request, accepted in IDLE or HALT
//   busy, halted                registered status, never both high
//   illegal                     sticky illegal-word flag
//   retired                     saturating count of executed instructions

module typer_multicycle
  import typer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          dbg_we,
  input  logic [4:0]                    dbg_addr,
  input  logic [DATA_W-1:0]             dbg_wdata,
  output logic [DATA_W-1:0]             dbg_rdata,
  input  logic                          start,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [15:0]                   retired
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t state, state_next;
  logic   busy_d, halted_d;

  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, alu_res;
  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [32];

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic       legal;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign shamt  = ir[SH_HI:SH_LO];
  assign funct  = ir[FN_HI:FN_LO];
  assign legal  = (opcode == 6'd0) && funct_supported(funct);

  // State register; busy/halted are registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= busy_d;
      halted <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_next = S_FETCH;
      S_FETCH:        state_next = S_DECODE;
      S_DECODE: begin
        if (ir == HALT_WORD) state_next = S_HALT;
        else if (!legal)     state_next = S_FETCH;
        else                 state_next = S_EXEC;
      end
      S_EXEC:         state_next = S_WB;
      S_WB:           state_next = S_FETCH;
      default:        state_next = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy_d   = (state_next == S_FETCH) || (state_next == S_DECODE) ||
               (state_next == S_EXEC)  || (state_next == S_WB);
    halted_d = (state_next == S_HALT);
  end

  typer_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .shamt  (shamt),
    .funct  (funct),
    .result (alu_res)
  );

  // Control/datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= '0;
            retired <= '0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: ir <= imem[pc];
        S_DECODE: begin
          if (ir != HALT_WORD) begin
            if (!legal) begin
              illegal <= 1'b1;
              pc      <= pc + PC_ONE;
            end else begin
              a_q <= regs[rs];
              b_q <= regs[rt];
            end
          end
        end
        S_EXEC: alu_q <= alu_res;
        S_WB: begin
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
          pc <= pc + PC_ONE;
        end
        default: ;
      endcase
    end
  end

  // Register file; r0 is never written so it always reads zero. Debug writes
  // only happen while idle, so they never collide with write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == S_WB) begin
      if (rd != 5'd0) regs[rd] <= alu_q;
    end else if (!busy && dbg_we && dbg_addr != 5'd0) begin
      regs[dbg_addr] <= dbg_wdata;
    end
  end

  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // Instruction memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (imem_we && !busy) imem[imem_waddr] <= imem_wdata;
  end

endmodule

// File: tb/tb_typer_multicycle.sv
// tb/tb_typer_multicycle.sv - self-checking bench for typer_multicycle

module tb_typer_multicycle;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int PW    = 6;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_we = 1'b0;
  logic [PW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic          dbg_we = 1'b0;
  logic [4:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] dbg_rdata;
  logic          start = 1'b0;
  logic          busy, halted, illegal;
  logic [15:0]   retired;

  always #5 clk = ~clk;

  typer_multicycle #(.DATA_W(DW), .IMEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .start      (start),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected per-cycle status after the accepting edge
  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;
  } snap_t;

  snap_t       exp_q[$];
  snap_t       pend_q[$];
  snap_t       cur;
  logic [31:0] m_imem [DEPTH];
  logic [31:0] m_regs [32];

  function automatic snap_t mk(input logic b, input logic h, input logic i, input logic [15:0] r);
    snap_t s;
    s.busy = b; s.halted = h; s.illegal = i; s.retired = r;
    return s;
  endfunction

  // Architectural interpreter: runs the program on the model register file
  // and lays out the cycle timeline (4 per R-type, 2 per illegal, 2 + halt).
  task automatic build_model();
    int          pc;
    logic [15:0] ret;
    logic        ill, ok;
    logic [31:0] w, av, bv, res;
    pc = 0; ret = 0; ill = 0;
    pend_q.delete();
    for (int guard = 0; guard < 256; guard++) begin
      w = m_imem[pc];
      if (w == HALT) begin
        repeat (2) pend_q.push_back(mk(1, 0, ill, ret));
        repeat (2) pend_q.push_back(mk(0, 1, ill, ret));
        break;
      end
      av = m_regs[w[25:21]];
      bv = m_regs[w[20:16]];
      ok = (w[31:26] == 6'd0);
      res = 0;
      case (w[5:0])
        6'h20: res = av + bv;
        6'h22: res = av - bv;
        6'h24: res = av & bv;
        6'h25: res = av | bv;
        6'h27: res = ~(av | bv);
        6'h2A: res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
        6'h00: res = bv << (w[10:6] % 32);
        6'h02: res = bv >> (w[10:6] % 32);
        default: ok = 0;
      endcase
      if (!ok) begin
        repeat (2) pend_q.push_back(mk(1, 0, ill, ret));
        ill = 1;
      end else begin
        repeat (4) pend_q.push_back(mk(1, 0, ill, ret));
        if (w[15:11] != 5'd0) m_regs[w[15:11]] = res;
        if (ret != 16'hFFFF) ret = ret + 16'd1;
      end
      pc = (pc + 1) % DEPTH;
    end
  endtask

  // Single compare process: status outputs against the model timeline
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("busy",    busy,    cur.busy);
      check("halted",  halted,  cur.halted);
      check("illegal", illegal, cur.illegal);
      check("retired", retired, cur.retired);
    end
  end

  task automatic imem_write(input int addr, input logic [31:0] w);
    imem_we = 1; imem_waddr = addr[PW-1:0]; imem_wdata = w;
    m_imem[addr] = w;
    @(posedge clk); #1 imem_we = 0;
  endtask

  task automatic reg_write(input int r, input logic [31:0] v);
    dbg_we = 1; dbg_addr = r[4:0]; dbg_wdata = v;
    if (r != 0) m_regs[r] = v;
    @(posedge clk); #1 dbg_we = 0;
  endtask

  task automatic rd(input int r, output logic [31:0] v);
    dbg_addr = r[4:0];
    #1 v = dbg_rdata;
  endtask

  // Returns just after the accepting edge E0
  task automatic start_prog();
    build_model();
    start = 1;
    @(posedge clk); #1 start = 0;
    exp_q = pend_q;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_regs(input string name);
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0];
      #1 check($sformatf("%s_r%0d", name, r), dbg_rdata, (r == 0) ? 32'd0 : m_regs[r]);
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] v;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < DEPTH; i++) m_imem[i] = HALT;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rd(7, v); check("rst_r7", v, 0);

    // Basic add with exact write-back and halt timing
    reg_write(1, 5);
    reg_write(2, 3);
    imem_write(0, 32'h0022_1820);
    imem_write(1, HALT);
    start_prog();
    repeat (3) @(posedge clk);
    rd(3, v); check("add_r3_before_E4", v, 0);
    @(posedge clk);
    rd(3, v); check("add_r3_at_E4", v, 8);
    @(posedge clk); #1 check("add_halted_E5", halted, 0);
    @(posedge clk); #1 check("add_halted_E6", halted, 1);
    wait_done("add");
    check("add_retired", retired, 1);
    check_regs("add");

    // Mixed ALU
    imem_write(0, 32'h0022_2022);
    imem_write(1, 32'h0041_282A);
    imem_write(2, 32'h0002_3100);
    imem_write(3, HALT);
    start_prog();
    wait_done("mix");
    rd(4, v); check("mix_r4", v, 2);
    rd(5, v); check("mix_r5", v, 1);
    rd(6, v); check("mix_r6", v, 48);
    check("mix_retired", retired, 3);
    check("mix_halted", halted, 1);
    check_regs("mix");

    // Zero register, wrap-around and remaining functs
    reg_write(1, 32'hFFFF_FFFF);
    reg_write(2, 1);
    imem_write(0, 32'h0022_0020);
    imem_write(1, 32'h0022_1820);
    imem_write(2, 32'h0022_3827);
    imem_write(3, 32'h0022_4024);
    imem_write(4, 32'h0022_4825);
    imem_write(5, 32'h0001_5702);
    imem_write(6, 32'h0022_582A);
    imem_write(7, HALT);
    start_prog();
    wait_done("wrap");
    rd(0, v);  check("wrap_r0", v, 0);
    rd(3, v);  check("wrap_r3", v, 0);
    rd(10, v); check("wrap_r10_srl", v, 32'hF);
    rd(11, v); check("wrap_r11_slt", v, 1);
    check("wrap_retired", retired, 7);
    check_regs("wrap");

    // Illegal opcode and unsupported funct
    imem_write(0, 32'h8C00_0000);
    imem_write(1, 32'h0022_1821);
    imem_write(2, HALT);
    start_prog();
    wait_done("ill");
    check("ill_flag", illegal, 1);
    check("ill_retired", retired, 0);
    check("ill_halted", halted, 1);
    imem_write(0, 32'h0022_1820);
    imem_write(1, HALT);
    start_prog();
    check("ill_cleared_on_start", illegal, 0);
    wait_done("ill2");
    check_regs("ill2");

    // Host writes and start during EXEC are ignored
    reg_write(1, 5);
    reg_write(2, 3);
    start_prog();
    repeat (2) @(posedge clk);
    #1;
    imem_we = 1; imem_waddr = '0; imem_wdata = 32'h0022_2022;
    dbg_we = 1; dbg_addr = 5'd1; dbg_wdata = 99;
    start = 1;
    @(posedge clk); #1;
    imem_we = 0; dbg_we = 0; start = 0;
    wait_done("busy");
    rd(3, v); check("busy_r3", v, 8);
    rd(1, v); check("busy_r1", v, 5);
    check_regs("busy");
    reg_write(3, 0);
    start_prog();
    wait_done("busy_rerun");
    rd(3, v); check("busy_rerun_r3", v, 8);

    // Reset during write-back
    start_prog();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_halted", halted, 0);
    check("mrst_retired", retired, 0);
    rd(3, v); check("mrst_r3", v, 0);
    @(posedge clk); #1 reset = 0;
    reg_write(1, 5);
    reg_write(2, 3);
    start_prog();
    wait_done("rerun");
    rd(3, v); check("rerun_r3", v, 8);
    check_regs("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/typer_multicycle.md
# typer_multicycle

Parametrised multicycle execution core for MIPS-format R-type instructions: fetches from an internal instruction memory, decodes, executes on a DATA_W-bit ALU and writes back to a 32-entry register file. It succeeds the single-cycle R-type datapath. It adds generic data width and program depth, a start/halt handshake, a retire counter, illegal-opcode detection, and host preload/readback ports for the register file and instruction memory. It sits under a testbench or host controller that loads a program, starts it and inspects the results.

## Interface
- DATA_W, 32: register and ALU width; legal range 8..64.
- IMEM_DEPTH, 64: instruction words; must be a power of two; PC width is log2(IMEM_DEPTH).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register listed below.
- imem_we  in  1  instruction-memory write strobe; honoured only when busy=0.
- imem_waddr  in  log2(IMEM_DEPTH)  write address.
- imem_wdata  in  32  instruction word.
- dbg_we  in  1  register-file write strobe; honoured only when busy=0; writes to r0 are discarded.
- dbg_addr  in  5  register index, shared by debug read and debug write.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  combinational read of reg[dbg_addr]; r0 reads 0.
- start  in  1  one-cycle request; accepted in IDLE or HALT only.
- busy  out  1  high in FETCH, DECODE, EXEC and WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky flag; cleared by reset or by an accepted start.
- retired  out  16  count of executed R-type instructions; saturates at 0xFFFF.

## Operation
- Reset values: state=IDLE, pc=0, all registers=0, busy=0, halted=0, illegal=0, retired=0. Instruction memory is not cleared.
- FSM states and transitions:
  - IDLE: on start, set pc=0, clear retired and illegal, go to FETCH.
  - FETCH: ir<=imem[pc]; go to DECODE.
  - DECODE:
    - ir==32'hFFFF_FFFF: go to HALT.
    - ir[31:26]!=0, or funct is unsupported: set illegal, pc<=pc+1, go to FETCH. retired is not counted.
    - otherwise: latch A=reg[rs] and B=reg[rt], go to EXEC.
  - EXEC: alu_q<=f(A,B,shamt); go to WB.
  - WB: if rd!=0, reg[rd]<=alu_q; retired<=sat(retired+1); pc<=pc+1 (modulo IMEM_DEPTH); go to FETCH.
  - HALT: on start, behave as in IDLE. Registers are kept.
- Supported funct codes:
  - 0x20 add: A+B, modulo 2^DATA_W.
  - 0x22 sub: A-B, modulo 2^DATA_W.
  - 0x24 and, 0x25 or, 0x27 nor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x00 sll: B<<sh.
  - 0x02 srl: B>>sh, logical.
  - sh = shamt mod DATA_W.
- PC wrap: after the last address the PC returns to 0. A program with no halt word runs forever.
- start while busy=1: ignored.
- imem_we or dbg_we while busy=1: ignored, no side effect.
- dbg_we and a WB to the same register cannot coincide, because debug writes require busy=0.
- Reset asserted mid-instruction: state returns to IDLE immediately (asynchronously). The partial instruction has no effect; the register file is cleared.

## Timing
- Start accepted at edge E0 (state IDLE→FETCH). FETCH→DECODE at E1, DECODE→EXEC at E2, EXEC→WB at E3. The WB write lands at E4 and is visible on dbg_rdata after E4.
- Throughput: 4 cycles per R-type instruction; 2 cycles for an illegal word; the halt word reaches HALT 2 cycles after entering FETCH.
- busy rises the cycle after start is sampled. busy and halted are registered and never both high.

## Structure
- Shared package typer_pkg: the funct localparams (ADD, SUB, AND, OR, NOR, SLT, SLL, SRL), the HALT_WORD constant, the FSM state enum, and instruction field bit positions.
- Sub-module typer_alu: combinational, parameter DATA_W, inputs a, b, shamt, funct, output result. The FSM, PC, register file and instruction memory stay in the top level.

## Test plan
- Basic add: dbg-write r1=5, r2=3. imem[0]=0x00221820 (add r3,r1,r2), imem[1]=0xFFFFFFFF. Pulse start → r3=8 after E4; halted=1 after E6; retired=1.
- Mixed ALU: r1=5, r2=3. Program sub r4,r1,r2 (0x00222022), slt r5,r2,r1 (0x0041282A), sll r6,r2,4 (0x00023100), halt → r4=2, r5=1, r6=48, retired=3, halted=1.
- Zero register and wrap: add r0,r1,r2 leaves r0=0. With r1=0xFFFFFFFF, r2=1, add r3 gives 0.
- Illegal word: imem[0]=0x8C000000, imem[1]=halt → illegal=1, retired=0, halted. A new start clears illegal.
- Busy protection: imem_we, dbg_we and start issued during EXEC → no memory or register change; the program completes normally.
- Reset mid-run: assert reset during WB of the add → state IDLE, busy=0, r3=0, retired=0 immediately (asynchronously). imem contents persist, and a rerun after reset gives r3=8 once r1 and r2 are reloaded.
